// File: rtl/line_burst_adapter.sv
// Splits L1 line fills and write-backs into MEM_BUS_WIDTH beats on a simple req/ack memory bus.
// Optional per-beat ack timeout: define LINE_BURST_ADAPTER_TIMEOUT_EN.
module line_burst_adapter #(
  parameter int CACHE_LINE_SIZE = 512,
  parameter int MEM_BUS_WIDTH   = 128,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_load,
  input  logic                       req_store,
  input  logic [63:0]                req_addr,
  input  logic [CACHE_LINE_SIZE-1:0] wline,
  output logic [CACHE_LINE_SIZE-1:0] rline,
  output logic                       ready,
  output logic                       bus_req,
  output logic                       bus_we,
  output logic [63:0]                bus_addr,
  output logic [MEM_BUS_WIDTH-1:0]   bus_wdata,
  input  logic [MEM_BUS_WIDTH-1:0]   bus_rdata,
  input  logic                       bus_ack,
  output logic                       err
);

  localparam int BEATS = CACHE_LINE_SIZE / MEM_BUS_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [63:0] BEAT_BYTES = 64'(MEM_BUS_WIDTH / 8);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR_BEAT = 2'd1;
  localparam logic [1:0] RD_BEAT = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]                 state;
  logic [CNT_W-1:0]           beat_cnt;
  logic                       resp_gap;
  logic [63:0]                base_addr;
  logic [CACHE_LINE_SIZE-1:0] wline_hold;
  logic                       accept;
  logic                       in_beat;
  logic                       timeout_hit;
  logic                       unused_addr;

  // resp_gap blanks the IDLE cycle right after RESP so a request the L1 is still dropping is not re-served
  assign accept  = (state == IDLE) && !resp_gap && (req_store || req_load);
  assign in_beat = (state == WR_BEAT) || (state == RD_BEAT);

  assign ready     = (state == RESP);
  assign bus_req   = in_beat;
  assign bus_we    = (state == WR_BEAT);
  assign bus_addr  = base_addr + 64'(beat_cnt) * BEAT_BYTES;
  assign bus_wdata = wline_hold[int'(beat_cnt)*MEM_BUS_WIDTH +: MEM_BUS_WIDTH];

  assign unused_addr = ^req_addr[5:0];

`ifdef LINE_BURST_ADAPTER_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_cnt;

  assign timeout_hit = in_beat && !bus_ack && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (!in_beat || bus_ack || timeout_hit) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout_hit) begin
        err <= 1'b1;
      end
    end
  end
`else
  logic unused_cfg;

  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
  assign unused_cfg  = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      resp_gap <= 1'b0;
      rline    <= '0;
    end else begin
      resp_gap <= (state == RESP);
      case (state)
        IDLE: begin
          if (accept) begin
            beat_cnt <= '0;
            state    <= req_store ? WR_BEAT : RD_BEAT;
          end
        end
        WR_BEAT, RD_BEAT: begin
          if (bus_ack) begin
            if (state == RD_BEAT) begin
              rline[int'(beat_cnt)*MEM_BUS_WIDTH +: MEM_BUS_WIDTH] <= bus_rdata;
            end
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              state <= RESP;
            end
          end else if (timeout_hit) begin
            // an abandoned fill must not hand the L1 a partially written line
            if (state == RD_BEAT) begin
              rline <= '0;
            end
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Line base and write-back data are plain data: captured on accept, no reset
  always_ff @(posedge clock) begin
    if (accept) begin
      base_addr <= {req_addr[63:6], 6'b0};
      if (req_store) begin
        wline_hold <= wline;
      end
    end
  end

endmodule
